// File: rtl/fir_driver.sv
// rtl/fir_driver.sv - sample FIFO and one-in-flight issue/collect sequencer for an external FIR
// Optional WAIT-state watchdog: define FIR_DRIVER_TIMEOUT_EN to build it in.
module fir_driver #(
  parameter int INPUT_WIDTH    = 16,
  parameter int OUTPUT_WIDTH   = 38,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INPUT_WIDTH-1:0]      s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [INPUT_WIDTH-1:0]      fir_input,
  output logic                        fir_input_valid,
  input  logic [OUTPUT_WIDTH-1:0]     fir_output,
  input  logic                        fir_output_valid,
  output logic [OUTPUT_WIDTH-1:0]     m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [INPUT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [INPUT_WIDTH-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [INPUT_WIDTH-1:0]  fir_input_q, fir_input_d;
  logic [OUTPUT_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic result_take;
  logic timeout_hit;

  // s_ready looks only at registered occupancy, so a same-cycle pop never frees a slot early
  assign s_ready       = (count_q < DEPTH_C);
  assign push          = s_valid && s_ready;
  assign fifo_nonempty = (count_q != '0);

  assign fifo_count = count_q;
  assign fir_input  = fir_input_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: pop only when no result is still waiting downstream, keeping one sample in flight
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty && !m_valid_q) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fir_output_valid || timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: start pulse, FIFO pop and result capture, all decoded from the current state
  always_comb begin
    fir_input_valid = 1'b0;
    pop             = 1'b0;
    result_take     = 1'b0;
    unique case (state_q)
      ST_IDLE:  pop             = fifo_nonempty && !m_valid_q;
      ST_ISSUE: fir_input_valid = 1'b1;
      ST_WAIT:  result_take     = fir_output_valid;
      default: begin
        fir_input_valid = 1'b0;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Sample and result holding registers; fir_input only changes on a pop so it is stable through WAIT
  always_comb begin
    fir_input_d = fir_input_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    if (pop) begin
      fir_input_d = mem_q[rd_ptr_q];
    end
    if (result_take) begin
      m_data_d  = fir_output;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fir_input_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fir_input_q <= fir_input_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
    end
  end

`ifdef FIR_DRIVER_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(TIMEOUT_CYCLES);

  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  // Watchdog count of WAIT cycles; cleared in ISSUE so every WAIT visit starts from zero
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_ISSUE) begin
      wait_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_d = wait_cnt_q + WCNT_W'(1);
    end
  end

  // A real result in the same cycle as expiry wins; expiry drops the sample and leaves m_valid alone
  assign timeout_hit   = (state_q == ST_WAIT) && !fir_output_valid && (wait_cnt_d == TIMEOUT_C);
  assign timeout_err_d = timeout_err_q || timeout_hit;
  assign timeout_err   = timeout_err_q;

  // Watchdog registers; the error flag is sticky until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  // No watchdog in this build: WAIT lasts until the FIR answers; the expression is constant zero
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_fir_driver.sv
// tb/tb_fir_driver.sv - scoreboard bench for fir_driver with a behavioural FIR responder
module tb_fir_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] fir_input;
  logic        fir_input_valid;
  logic [37:0] fir_output;
  logic        fir_output_valid;
  logic [37:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  fifo_count;
  logic        timeout_err;

  logic        model_valid;
  logic [37:0] model_data;
  logic        inject_valid;
  logic [37:0] inject_data;

  assign fir_output_valid = model_valid | inject_valid;
  assign fir_output       = model_valid ? model_data : inject_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [37:0] exp_q [$];

  int          fir_delay = 70;
  bit          fir_stall = 0;
  bit          fir_busy = 0;
  int          fir_cnt = 0;
  int          pulse_count = 0;
  int          last_pulse_cyc = 0;
  logic [15:0] pulse_data = '0;
  int          mv_cycles = 0;
  int          hs_cyc = 0;

  fir_driver #(
    .INPUT_WIDTH(16),
    .OUTPUT_WIDTH(38),
    .FIFO_DEPTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .fir_input(fir_input),
    .fir_input_valid(fir_input_valid),
    .fir_output(fir_output),
    .fir_output_valid(fir_output_valid),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .fifo_count(fifo_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [37:0] fir_ref(input logic [15:0] x);
    return ({22'd0, x} * 38'd3) + 38'h10_0000_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIR model: latch the sample at the pulse, answer fir_delay cycles later unless stalled
  initial begin
    model_valid = 1'b0;
    model_data  = '0;
    forever begin
      @(negedge clk);
      model_valid = 1'b0;
      if (!reset) begin
        fir_busy = 0;
      end else if (fir_input_valid) begin
        pulse_count++;
        last_pulse_cyc = cyc;
        pulse_data     = fir_input;
        fir_busy       = 1;
        fir_cnt        = 0;
        chk("issue_with_result_pending", {63'd0, m_valid}, 64'd0);
      end else if (fir_busy) begin
        fir_cnt++;
        if (fir_cnt == 1) chk("fir_input_after_pulse", {48'd0, fir_input}, {48'd0, pulse_data});
        if (fir_cnt >= fir_delay && !fir_stall) begin
          chk("fir_input_at_result", {48'd0, fir_input}, {48'd0, pulse_data});
          model_data  = fir_ref(fir_input);
          model_valid = 1'b1;
          fir_busy    = 0;
        end
      end
    end
  end

  // Monitor: compare each accepted result against the scoreboard and check hold stability
  bit          hold_prev = 0;
  logic [37:0] hold_data = '0;
  always @(negedge clk) begin
    if (reset && m_valid) begin
      mv_cycles++;
      if (hold_prev) chk("m_data_hold", {26'd0, m_data}, {26'd0, hold_data});
      if (m_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_m_valid", 64'd1, 64'd0);
        end else begin
          chk("m_data", {26'd0, m_data}, {26'd0, exp_q.pop_front()});
        end
        hold_prev = 0;
      end else begin
        hold_prev = 1;
        hold_data = m_data;
      end
    end else begin
      hold_prev = 0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge
  task automatic send(input logic [15:0] d);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("send_ready_timeout", 64'd0, 64'd1);
    hs_cyc = cyc;
    @(negedge clk);
    s_valid = 1'b0;
    exp_q.push_back(fir_ref(d));
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {63'd0, (exp_q.size() == 0)}, 64'd1);
    wait_cycles(3);
  endtask

  task automatic wait_pulses(input int target, input int limit);
    int n = 0;
    while (pulse_count < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_wait", pulse_count, target);
  endtask

  task automatic inject_result(input logic [37:0] d);
    inject_data  = d;
    inject_valid = 1'b1;
    @(negedge clk);
    inject_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int pc;
    int tcyc;
    int n;
    bit seen;
    reset        = 1'b0;
    s_data       = '0;
    s_valid      = 1'b0;
    m_ready      = 1'b1;
    inject_valid = 1'b0;
    inject_data  = '0;

    // Reset state
    wait_cycles(3);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_fifo_count", {60'd0, fifo_count}, 64'd0);
    chk("rst_fir_input", {48'd0, fir_input}, 64'd0);
    chk("rst_fir_input_valid", {63'd0, fir_input_valid}, 64'd0);
    chk("rst_m_data", {26'd0, m_data}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    reset = 1'b1;
    wait_cycles(2);

    // Single sample, 70-cycle FIR, 2-cycle issue latency, one-cycle m_valid
    fir_delay = 70;
    mv_cycles = 0;
    pc = pulse_count;
    send(16'h1234);
    wait_drain(300);
    chk("t1_pulse_count", pulse_count - pc, 1);
    chk("t1_issue_latency", last_pulse_cyc - hs_cyc, 2);
    chk("t1_m_valid_cycles", mv_cycles, 1);
    chk("t1_fir_input_kept", {48'd0, fir_input}, 64'h1234);

    // FIFO fill with one sample stalled in the FIR
    fir_delay = 3;
    fir_stall = 1;
    pc = pulse_count;
    send(16'h0A00);
    wait_pulses(pc + 1, 20);
    for (int i = 1; i <= 8; i++) send(16'h0A00 + 16'(i));
    chk("t2_count_full", {60'd0, fifo_count}, 64'd8);
    chk("t2_ready_low", {63'd0, s_ready}, 64'd0);
    s_data  = 16'h0A09;
    s_valid = 1'b1;
    wait_cycles(5);
    chk("t2_ninth_held_count", {60'd0, fifo_count}, 64'd8);
    chk("t2_ninth_held_ready", {63'd0, s_ready}, 64'd0);
    fir_stall = 0;
    send(16'h0A09);
    wait_drain(2000);
    chk("t2_pulse_total", pulse_count - pc, 10);

    // Back-pressure: result pending, 3 queued, no issue until m_ready
    fir_delay = 5;
    m_ready   = 1'b0;
    pc = pulse_count;
    send(16'h0B01);
    send(16'h0B02);
    send(16'h0B03);
    send(16'h0B04);
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_result_pending", {63'd0, m_valid}, 64'd1);
    wait_cycles(20);
    chk("t3_no_issue", pulse_count - pc, 1);
    chk("t3_queued", {60'd0, fifo_count}, 64'd3);
    chk("t3_m_data_held", {26'd0, m_data}, {26'd0, fir_ref(16'h0B01)});
    m_ready = 1'b1;
    wait_drain(500);
    chk("t3_pulse_total", pulse_count - pc, 4);

    // fir_output_valid in IDLE must be ignored
    seen = 0;
    inject_result(38'h3F_DEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen |= m_valid;
    end
    chk("t4_no_spurious", {63'd0, seen}, 64'd0);
    send(16'h0C55);
    wait_drain(300);

    // Reset mid-WAIT with 4 queued
    fir_stall = 1;
    pc = pulse_count;
    send(16'h0D00);
    wait_pulses(pc + 1, 20);
    for (int i = 1; i <= 4; i++) send(16'h0D00 + 16'(i));
    chk("t5_queued", {60'd0, fifo_count}, 64'd4);
    reset = 1'b0;
    #1;
    chk("t5_fifo_count", {60'd0, fifo_count}, 64'd0);
    chk("t5_fir_input", {48'd0, fir_input}, 64'd0);
    chk("t5_fir_input_valid", {63'd0, fir_input_valid}, 64'd0);
    chk("t5_m_valid", {63'd0, m_valid}, 64'd0);
    chk("t5_s_ready", {63'd0, s_ready}, 64'd1);
    exp_q.delete();
    wait_cycles(2);
    reset     = 1'b1;
    fir_stall = 0;
    pc   = pulse_count;
    seen = 0;
    inject_result(38'h12_3456_789A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= m_valid;
    end
    chk("t5_late_result_ignored", {63'd0, seen}, 64'd0);
    chk("t5_no_issue_after_reset", pulse_count - pc, 0);
    send(16'h0E77);
    wait_drain(300);

`ifdef FIR_DRIVER_TIMEOUT_EN
    // Watchdog: 16 WAIT cycles with no answer, then the next queued sample issues
    fir_stall = 1;
    pc = pulse_count;
    send(16'h0F01);
    send(16'h0F02);
    n = 0;
    while (!timeout_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    tcyc = cyc;
    chk("t6_timeout_set", {63'd0, timeout_err}, 64'd1);
    chk("t6_timeout_latency", tcyc - last_pulse_cyc, 17);
    chk("t6_m_valid_untouched", {63'd0, m_valid}, 64'd0);
    void'(exp_q.pop_front());
    wait_pulses(pc + 2, 10);
    fir_stall = 0;
    wait_drain(300);
    chk("t6_timeout_sticky", {63'd0, timeout_err}, 64'd1);
`else
    // No watchdog: a silent FIR keeps the sequencer in WAIT
    fir_stall = 1;
    pc = pulse_count;
    send(16'h0F01);
    wait_cycles(600);
    chk("t6_no_timeout_flag", {63'd0, timeout_err}, 64'd0);
    chk("t6_still_waiting", pulse_count - pc, 1);
    fir_stall = 0;
    wait_drain(300);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
